// File: rtl/coloring_pkg.sv
// rtl/coloring_pkg.sv - shared types and default constants for the colouring checker
package coloring_pkg;

   typedef enum logic [1:0] {
      REASON_NONE = 2'd0,
      REASON_RUN  = 2'd1,
      REASON_ADJ  = 2'd2
   } reason_t;

   typedef enum logic {
      EMPTY = 1'b0,
      TRACK = 1'b1
   } state_t;

   localparam int unsigned DEF_COLOR_W     = 2;
   localparam int unsigned DEF_RUN_MAX     = 2;
   localparam int unsigned DEF_CNT_W       = 8;
   localparam logic [15:0] DEF_FORBID_MASK = 16'h0012;

endpackage

// File: rtl/coloring_if.sv
// rtl/coloring_if.sv - colour source / painter-side bus of the colouring checker
interface coloring_if #(
   parameter int unsigned COLOR_W = 2,
   parameter int unsigned RUN_W   = 2,
   parameter int unsigned CNT_W   = 8
) ();
   import coloring_pkg::*;

   logic               clear;
   logic               in_valid;
   logic [COLOR_W-1:0] color;
   logic               check;
   logic               accept;
   reason_t            reason;
   logic [COLOR_W-1:0] last_color;
   logic [RUN_W-1:0]   run_len;
   logic [CNT_W-1:0]   accept_cnt;
   logic [CNT_W-1:0]   reject_cnt;

   modport master (
      output clear, in_valid, color,
      input  check, accept, reason, last_color, run_len, accept_cnt, reject_cnt
   );

   modport slave (
      input  clear, in_valid, color,
      output check, accept, reason, last_color, run_len, accept_cnt, reject_cnt
   );

endinterface

// File: rtl/coloring_rule.sv
// rtl/coloring_rule.sv - combinational run-length and forbidden-adjacency rule check
module coloring_rule
   import coloring_pkg::*;
#(
   parameter int unsigned COLOR_W = DEF_COLOR_W,
   parameter int unsigned RUN_MAX = DEF_RUN_MAX,
   parameter int unsigned RUN_W   = $clog2(RUN_MAX + 1),
   parameter logic [(1 << (2 * COLOR_W))-1:0] FORBID_MASK = DEF_FORBID_MASK
) (
   input  state_t             i_state,
   input  logic [COLOR_W-1:0] i_last_color,
   input  logic [RUN_W-1:0]   i_run_len,
   input  logic [COLOR_W-1:0] i_color,
   output logic               o_reject,
   output reason_t            o_reason
);

   logic [2*COLOR_W-1:0] w_pair_idx;
   logic                 w_adj_hit;
   logic                 w_run_hit;

   // {prev, cur} is exactly prev*NUM_COLORS + cur
   assign w_pair_idx = {i_last_color, i_color};
   assign w_adj_hit  = FORBID_MASK[w_pair_idx];
   assign w_run_hit  = (i_color == i_last_color) && (i_run_len == RUN_W'(RUN_MAX));

   always_comb begin
      o_reject = 1'b0;
      o_reason = REASON_NONE;
      if (i_state == TRACK) begin
         if (w_adj_hit) begin
            o_reject = 1'b1;
            o_reason = REASON_ADJ;
         end else if (w_run_hit) begin
            o_reject = 1'b1;
            o_reason = REASON_RUN;
         end
      end
   end

endmodule

// File: rtl/coloring_checker.sv
// rtl/coloring_checker.sv - strip-colouring checker top: FSM, history, counters, verdict regs
// Optional COLORING_STICKY_EN: check latches at first rejection until rst/clear.
module coloring_checker
   import coloring_pkg::*;
#(
   parameter int unsigned COLOR_W = DEF_COLOR_W,
   parameter int unsigned RUN_MAX = DEF_RUN_MAX,
   parameter logic [(1 << (2 * COLOR_W))-1:0] FORBID_MASK = DEF_FORBID_MASK,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input logic       clk,
   input logic       rst,
   coloring_if.slave bus
);

   localparam int unsigned RUN_W = $clog2(RUN_MAX + 1);

   state_t             r_state;
   state_t             w_state_next;
   logic               r_check;
   logic               r_accept;
   reason_t            r_reason;
   logic [COLOR_W-1:0] r_last_color;
   logic [RUN_W-1:0]   r_run_len;
   logic [CNT_W-1:0]   r_accept_cnt;
   logic [CNT_W-1:0]   r_reject_cnt;

   logic               w_reject;
   reason_t            w_rule_reason;
   logic               w_check_n;
   logic               w_accept_n;
   reason_t            w_reason_n;
   logic [COLOR_W-1:0] w_last_color_n;
   logic [RUN_W-1:0]   w_run_len_n;
   logic [CNT_W-1:0]   w_accept_cnt_n;
   logic [CNT_W-1:0]   w_reject_cnt_n;

   coloring_rule #(
      .COLOR_W     (COLOR_W),
      .RUN_MAX     (RUN_MAX),
      .RUN_W       (RUN_W),
      .FORBID_MASK (FORBID_MASK)
   ) u_rule (
      .i_state      (r_state),
      .i_last_color (r_last_color),
      .i_run_len    (r_run_len),
      .i_color      (bus.color),
      .o_reject     (w_reject),
      .o_reason     (w_rule_reason)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.clear) begin
         w_state_next = EMPTY;
      end else if (bus.in_valid && (r_state == EMPTY)) begin
         w_state_next = TRACK;
      end
   end

   always_comb begin
      w_check_n      = 1'b0;
      w_accept_n     = 1'b0;
      w_reason_n     = REASON_NONE;
      w_last_color_n = r_last_color;
      w_run_len_n    = r_run_len;
      w_accept_cnt_n = r_accept_cnt;
      w_reject_cnt_n = r_reject_cnt;
      if (bus.clear) begin
         w_last_color_n = '0;
         w_run_len_n    = '0;
         w_accept_cnt_n = '0;
         w_reject_cnt_n = '0;
      end else begin
         if (bus.in_valid) begin
            if (w_reject) begin
               w_check_n      = 1'b1;
               w_reason_n     = w_rule_reason;
               w_reject_cnt_n = (&r_reject_cnt) ? r_reject_cnt : r_reject_cnt + CNT_W'(1);
            end else begin
               w_accept_n     = 1'b1;
               w_last_color_n = bus.color;
               w_run_len_n    = ((r_state == TRACK) && (bus.color == r_last_color))
                                ? r_run_len + RUN_W'(1) : RUN_W'(1);
               w_accept_cnt_n = (&r_accept_cnt) ? r_accept_cnt : r_accept_cnt + CNT_W'(1);
            end
         end
`ifdef COLORING_STICKY_EN
         if (r_check) begin
            w_check_n  = 1'b1;
            w_reason_n = r_reason;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_check      <= 1'b0;
         r_accept     <= 1'b0;
         r_reason     <= REASON_NONE;
         r_last_color <= '0;
         r_run_len    <= '0;
         r_accept_cnt <= '0;
         r_reject_cnt <= '0;
      end else begin
         r_check      <= w_check_n;
         r_accept     <= w_accept_n;
         r_reason     <= w_reason_n;
         r_last_color <= w_last_color_n;
         r_run_len    <= w_run_len_n;
         r_accept_cnt <= w_accept_cnt_n;
         r_reject_cnt <= w_reject_cnt_n;
      end
   end

   assign bus.check      = r_check;
   assign bus.accept     = r_accept;
   assign bus.reason     = r_reason;
   assign bus.last_color = r_last_color;
   assign bus.run_len    = r_run_len;
   assign bus.accept_cnt = r_accept_cnt;
   assign bus.reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_coloring_checker.sv
// tb/tb_coloring_checker.sv - scoreboard bench for coloring_checker (CNT_W=2, other params default)
// Honours COLORING_STICKY_EN when the design is built with it.
module tb_coloring_checker;

   typedef struct packed {
      logic       chk;
      logic       acc;
      logic [1:0] rsn;
      logic [1:0] last;
      logic [1:0] run;
      logic [1:0] acnt;
      logic [1:0] rcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_beat   = 0;
   exp_t q[$];
   exp_t m_exp;
   exp_t m_act;
   logic       s_flag = 1'b0;
   logic [1:0] s_rsn  = 2'd0;

   coloring_if #(.COLOR_W(2), .RUN_W(2), .CNT_W(2)) bus ();

   coloring_checker #(.CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t sample();
      exp_t a;
      a = {bus.check, bus.accept, bus.reason, bus.last_color, bus.run_len,
           bus.accept_cnt, bus.reject_cnt};
      return a;
   endfunction

   always @(negedge clk) begin
      if (!rst && (q.size() > 0)) begin
         m_exp = q.pop_front();
         m_act = sample();
         n_assert++;
         if (m_act !== m_exp) begin
            n_fail++;
            $display("FAIL beat%0d chk/acc/rsn/last/run/acnt/rcnt got %b/%b/%0d/%0d/%0d/%0d/%0d want %b/%b/%0d/%0d/%0d/%0d/%0d",
                     n_beat, m_act.chk, m_act.acc, m_act.rsn, m_act.last, m_act.run, m_act.acnt, m_act.rcnt,
                     m_exp.chk, m_exp.acc, m_exp.rsn, m_exp.last, m_exp.run, m_exp.acnt, m_exp.rcnt);
         end
         n_beat++;
      end
   end

   task automatic row(input logic clr, v, input logic [1:0] col, input logic chk, acc,
                      input logic [1:0] rsn, last, run, acnt, rcnt);
      exp_t e;
      @(negedge clk);
      #1;
      bus.clear    = clr;
      bus.in_valid = v;
      bus.color    = col;
      e = {chk, acc, rsn, last, run, acnt, rcnt};
`ifdef COLORING_STICKY_EN
      if (clr) begin
         s_flag = 1'b0;
         s_rsn  = 2'd0;
      end else if (s_flag) begin
         e.chk = 1'b1;
         e.rsn = s_rsn;
      end else if (chk) begin
         s_flag = 1'b1;
         s_rsn  = rsn;
      end
`endif
      q.push_back(e);
   endtask

   task automatic check_zero(input string name);
      exp_t a;
      a = sample();
      n_assert++;
      if (a !== '0) begin
         n_fail++;
         $display("FAIL %s outputs got %h want 0", name, a);
      end
   endtask

   initial begin
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.color    = 2'd0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      #1 rst = 1'b0;

      //  clr v col  chk acc rsn last run acnt rcnt
      row(0, 0, 0,   0, 0, 0,  0,  0,  0,  0);
      row(0, 1, 2,   0, 1, 0,  2,  1,  1,  0);
      row(0, 1, 2,   0, 1, 0,  2,  2,  2,  0);
      row(0, 1, 2,   1, 0, 1,  2,  2,  2,  1);   // third 2: run violation
      row(0, 1, 0,   0, 1, 0,  0,  1,  3,  1);
      row(0, 1, 1,   1, 0, 2,  0,  1,  3,  2);   // 0->1 forbidden
      row(0, 1, 2,   0, 1, 0,  2,  1,  3,  2);   // accept count saturated
      row(0, 0, 3,   0, 0, 0,  2,  1,  3,  2);
      row(0, 0, 1,   0, 0, 0,  2,  1,  3,  2);
      row(0, 0, 0,   0, 0, 0,  2,  1,  3,  2);
      row(0, 1, 2,   0, 1, 0,  2,  2,  3,  2);
      row(0, 1, 2,   1, 0, 1,  2,  2,  3,  3);
      row(0, 1, 2,   1, 0, 1,  2,  2,  3,  3);   // reject count saturated
      row(1, 1, 0,   0, 0, 0,  0,  0,  0,  0);   // clear beats valid
      row(0, 1, 1,   0, 1, 0,  1,  1,  1,  0);
      row(0, 1, 0,   1, 0, 2,  1,  1,  1,  1);   // 1->0 forbidden
      row(0, 1, 1,   0, 1, 0,  1,  2,  2,  1);
      row(0, 1, 1,   1, 0, 1,  1,  2,  2,  2);
      row(0, 1, 0,   1, 0, 2,  1,  2,  2,  3);
      row(0, 1, 3,   0, 1, 0,  3,  1,  3,  3);
      row(0, 1, 3,   0, 1, 0,  3,  2,  3,  3);
      row(0, 1, 2,   0, 1, 0,  2,  1,  3,  3);
      row(0, 1, 3,   0, 1, 0,  3,  1,  3,  3);

      @(negedge clk);
      #3 rst = 1'b1;
      #1 check_zero("async_reset");
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      s_flag = 1'b0;
      s_rsn  = 2'd0;
      @(negedge clk);
      #1 rst = 1'b0;

      row(0, 1, 3,   0, 1, 0,  3,  1,  1,  0);
      row(0, 0, 0,   0, 0, 0,  3,  1,  1,  0);
      row(1, 0, 0,   0, 0, 0,  0,  0,  0,  0);
      row(0, 1, 0,   0, 1, 0,  0,  1,  1,  0);
      row(0, 1, 1,   1, 0, 2,  0,  1,  1,  1);
      row(0, 1, 2,   0, 1, 0,  2,  1,  2,  1);
      row(0, 0, 0,   0, 0, 0,  2,  1,  2,  1);
      row(1, 0, 0,   0, 0, 0,  0,  0,  0,  0);
      row(0, 0, 0,   0, 0, 0,  0,  0,  0,  0);

      repeat (2) @(negedge clk);
      #1;
      n_assert++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain pending got %0d want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog expired got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
